// File: rtl/status_array_mem_pkg.sv
// Purpose : shared geometry of the instruction-cache status array (row/address/mask widths).
// Latency : n/a (constants and types only).
// Backpr. : n/a.
package status_array_mem_pkg;

  localparam int ADDR_WIDTH  = 6;
  localparam int ROW_WIDTH   = 8;
  localparam int NUM_BLOCKS  = 4;
  localparam int BLOCK_WIDTH = ROW_WIDTH / NUM_BLOCKS;
  localparam int NUM_ROWS    = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [ROW_WIDTH-1:0]  row_t;
  typedef logic [NUM_BLOCKS-1:0] mask_t;

endpackage

// File: rtl/status_array_mem_if.sv
// Purpose : request/response bundle between status-array requesters and the storage responder.
// Latency : n/a (wires only). master = requester (initializer, lookup/update), slave = storage.
// Backpr. : o_ready low (halt or reset) means the presented request is not taken this cycle.
interface status_array_mem_if;
  import status_array_mem_pkg::*;

  addr_t i_addr;    // row address
  row_t  i_data;    // write data
  logic  i_wen;     // 1 = write, 0 = read
  mask_t i_wmask;   // per-block write enable
  logic  i_valid;   // request present
  logic  o_ready;   // request accepted this cycle if i_valid
  row_t  o_rdata;   // read data
  addr_t o_raddr;   // address of returned read
  logic  o_rvalid;  // o_rdata/o_raddr valid

  modport master (
    output i_addr, i_data, i_wen, i_wmask, i_valid,
    input  o_ready, o_rdata, o_raddr, o_rvalid
  );

  modport slave (
    input  i_addr, i_data, i_wen, i_wmask, i_valid,
    output o_ready, o_rdata, o_raddr, o_rvalid
  );

endinterface

// File: rtl/status_array_mem.sv
// Purpose : NUM_ROWS x ROW_WIDTH status array with per-block masked writes and a 1-deep read response.
// Latency : read data valid 1 cycle after accept; one request per cycle; writes give no response.
// Backpr. : o_ready = ~i_halt & ~srst; halt freezes array and response regs, srst clears the response.
// Ports   : clk, srst (sync, active high), i_halt (stall), bus (status_array_mem_if.slave).
module status_array_mem
  import status_array_mem_pkg::*;
(
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 i_halt,
  status_array_mem_if.slave    bus
);

  // Storage is deliberately not reset: the initializer zeroes it through the normal write path.
  row_t  mem_q [NUM_ROWS];

  row_t  rdata_q,  rdata_d;
  addr_t raddr_q,  raddr_d;
  logic  rvalid_q, rvalid_d;

  logic  accept;
  logic  rd_accept;
  logic  wr_accept;
  row_t  cur_row;
  row_t  mem_row_d;

  assign bus.o_ready = ~i_halt & ~srst;
  assign accept      = bus.i_valid & bus.o_ready;
  assign rd_accept   = accept & ~bus.i_wen;
  assign wr_accept   = accept &  bus.i_wen;

  assign cur_row     = mem_q[bus.i_addr];

  // Merge the new data into the current row block by block; unmasked blocks keep their contents.
  for (genvar b = 0; b < NUM_BLOCKS; b++) begin : g_blk
    assign mem_row_d[b*BLOCK_WIDTH +: BLOCK_WIDTH] =
      bus.i_wmask[b] ? bus.i_data[b*BLOCK_WIDTH +: BLOCK_WIDTH]
                     : cur_row[b*BLOCK_WIDTH +: BLOCK_WIDTH];
  end

  // wr_accept already excludes halt and reset, so no partial write can happen in those cycles.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[bus.i_addr] <= mem_row_d;
    end
  end

  always_comb begin
    rdata_d  = rdata_q;
    raddr_d  = raddr_q;
    rvalid_d = rvalid_q;
    // Under halt everything holds, including a response that was already being presented.
    if (!i_halt) begin
      rvalid_d = rd_accept;
      if (rd_accept) begin
        rdata_d = cur_row;
        raddr_d = bus.i_addr;
      end
    end
  end

  // Reset wins over halt: a pending response is dropped even while stalled.
  always_ff @(posedge clk) begin
    if (srst) begin
      rdata_q  <= '0;
      raddr_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      raddr_q  <= raddr_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign bus.o_rdata  = rdata_q;
  assign bus.o_raddr  = raddr_q;
  assign bus.o_rvalid = rvalid_q;

endmodule

// File: tb/tb_status_array_mem.sv
// Purpose : directed self-checking bench for status_array_mem.
// Latency : outputs checked 1 time unit after each rising edge, inputs changed at the same point.
// Backpr. : drives o_ready corner cases (halt, reset) directly.
module tb_status_array_mem;
  import status_array_mem_pkg::*;

  logic clk;
  logic srst;
  logic i_halt;
  int   n_vec;
  int   n_bad;

  status_array_mem_if bus ();

  status_array_mem dut (
    .clk    (clk),
    .srst   (srst),
    .i_halt (i_halt),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic w, input int a, input logic [7:0] d, input logic [3:0] m);
    bus.i_valid = v;
    bus.i_wen   = w;
    bus.i_addr  = addr_t'(a);
    bus.i_data  = d;
    bus.i_wmask = m;
  endtask

  initial begin
    n_vec  = 0;
    n_bad  = 0;
    srst   = 1'b1;
    i_halt = 1'b0;
    drive(1'b0, 1'b0, 0, 8'h00, 4'h0);

    // Reset state
    tick();
    tick();
    chk("rst_rvalid", 32'(bus.o_rvalid), 32'd0);
    chk("rst_rdata",  32'(bus.o_rdata),  32'h00);
    chk("rst_raddr",  32'(bus.o_raddr),  32'd0);
    chk("rst_ready",  32'(bus.o_ready),  32'd0);
    srst = 1'b0;
    #1;
    chk("ready_idle", 32'(bus.o_ready),  32'd1);

    // Initializer pattern: zero every row
    for (int a = 0; a < NUM_ROWS; a++) begin
      drive(1'b1, 1'b1, a, 8'h00, 4'hF);
      tick();
    end
    chk("init_wr_norsp", 32'(bus.o_rvalid), 32'd0);

    // Back-to-back reads of all rows
    for (int a = 0; a < NUM_ROWS; a++) begin
      drive(1'b1, 1'b0, a, 8'hEE, 4'hF);
      tick();
      chk("sweep_rvalid", 32'(bus.o_rvalid), 32'd1);
      chk("sweep_rdata",  32'(bus.o_rdata),  32'h00);
      chk("sweep_raddr",  32'(bus.o_raddr),  32'(a));
    end
    drive(1'b0, 1'b0, 0, 8'h00, 4'h0);
    tick();
    chk("idle_rvalid",  32'(bus.o_rvalid), 32'd0);
    chk("idle_raddr",   32'(bus.o_raddr),  32'd63);

    // Masked partial write: FF then 00 on blocks 0 and 2 -> CC
    drive(1'b1, 1'b1, 5, 8'hFF, 4'b1111);
    tick();
    drive(1'b1, 1'b1, 5, 8'h00, 4'b0101);
    tick();
    drive(1'b1, 1'b0, 5, 8'h00, 4'b0000);
    tick();
    chk("mask_rdata",  32'(bus.o_rdata),  32'hCC);
    chk("mask_rvalid", 32'(bus.o_rvalid), 32'd1);

    // Write then immediate read, top row
    drive(1'b1, 1'b1, 63, 8'hA5, 4'hF);
    tick();
    chk("wr_no_rsp", 32'(bus.o_rvalid), 32'd0);
    drive(1'b1, 1'b0, 63, 8'h00, 4'h0);
    tick();
    chk("w2r_rdata", 32'(bus.o_rdata), 32'hA5);
    chk("w2r_raddr", 32'(bus.o_raddr), 32'd63);

    // Halt holds the response and blocks the held request
    drive(1'b1, 1'b1, 3, 8'h5A, 4'hF);
    tick();
    drive(1'b1, 1'b0, 3, 8'h00, 4'h0);
    tick();
    chk("pre_halt_rdata", 32'(bus.o_rdata), 32'h5A);
    drive(1'b1, 1'b0, 5, 8'h00, 4'h0);
    i_halt = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("halt_ready", 32'(bus.o_ready), 32'd0);
      tick();
      chk("halt_rvalid", 32'(bus.o_rvalid), 32'd1);
      chk("halt_rdata",  32'(bus.o_rdata),  32'h5A);
      chk("halt_raddr",  32'(bus.o_raddr),  32'd3);
    end
    i_halt = 1'b0;
    tick();
    chk("unhalt_rdata", 32'(bus.o_rdata), 32'hCC);
    chk("unhalt_raddr", 32'(bus.o_raddr), 32'd5);

    // A write held under halt must not land
    drive(1'b1, 1'b1, 5, 8'h11, 4'hF);
    i_halt = 1'b1;
    tick();
    tick();
    i_halt = 1'b0;
    drive(1'b1, 1'b0, 5, 8'h00, 4'h0);
    tick();
    chk("halt_wr_blocked", 32'(bus.o_rdata), 32'hCC);

    // Reset right after a read accept, with a write to addr 9 in the reset cycle
    drive(1'b1, 1'b1, 9, 8'h42, 4'hF);
    tick();
    drive(1'b1, 1'b0, 9, 8'h00, 4'h0);
    tick();
    chk("pre_rst_rdata", 32'(bus.o_rdata), 32'h42);
    srst = 1'b1;
    drive(1'b1, 1'b1, 9, 8'h77, 4'hF);
    #1;
    chk("rst_ready_wr", 32'(bus.o_ready), 32'd0);
    tick();
    chk("midrst_rvalid", 32'(bus.o_rvalid), 32'd0);
    chk("midrst_rdata",  32'(bus.o_rdata),  32'h00);
    chk("midrst_raddr",  32'(bus.o_raddr),  32'd0);
    srst = 1'b0;
    drive(1'b1, 1'b0, 9, 8'h00, 4'h0);
    tick();
    chk("rst_no_write", 32'(bus.o_rdata), 32'h42);
    chk("rst_rd_raddr", 32'(bus.o_raddr), 32'd9);

    // Reset has priority over halt
    srst   = 1'b1;
    i_halt = 1'b1;
    drive(1'b0, 1'b0, 0, 8'h00, 4'h0);
    tick();
    chk("rst_over_halt", 32'(bus.o_rvalid), 32'd0);
    chk("rst_over_halt_d", 32'(bus.o_rdata), 32'h00);
    srst   = 1'b0;
    i_halt = 1'b0;

    // Zero mask write is a no-op
    drive(1'b1, 1'b1, 2, 8'h3C, 4'hF);
    tick();
    drive(1'b1, 1'b1, 2, 8'hFF, 4'b0000);
    tick();
    chk("m0_no_rsp", 32'(bus.o_rvalid), 32'd0);
    drive(1'b1, 1'b0, 2, 8'h00, 4'h0);
    tick();
    chk("m0_rdata", 32'(bus.o_rdata), 32'h3C);
    chk("m0_raddr", 32'(bus.o_raddr), 32'd2);
    drive(1'b0, 1'b0, 0, 8'h00, 4'h0);
    tick();
    chk("end_idle", 32'(bus.o_rvalid), 32'd0);
    chk("end_hold", 32'(bus.o_rdata),  32'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/status_array_mem.md
# status_array_mem

Storage responder for the instruction-cache status array: a `2**ADDR_WIDTH` × `ROW_WIDTH` register array. It is the far end of the addr/data/wen/wmask/valid request interface driven by the status-array initializer and by the lookup/update logic. It performs per-block masked writes and returns read data with one-cycle latency. Halt freezes the array and the response registers, matching the upstream stall semantics.

## Interface
Parameters (from `shared_params.vh`):
- `ADDR_WIDTH`, 6: row address width; `NUM_ROWS = 2**ADDR_WIDTH`.
- `ROW_WIDTH`, 8: bits per row.
- `NUM_BLOCKS`, 4: write-mask granularity; `BLOCK_WIDTH = ROW_WIDTH/NUM_BLOCKS`, which must be an integer.

Ports:
- `clk` in 1: single clock, rising edge.
- `srst` in 1: synchronous, active-high reset.
- `i_halt` in 1: stall; freezes all state.
- `i_addr` in ADDR_WIDTH: row address.
- `i_data` in ROW_WIDTH: write data.
- `i_wen` in 1: 1 = write, 0 = read.
- `i_wmask` in NUM_BLOCKS: bit b enables row bits `[b*BLOCK_WIDTH +: BLOCK_WIDTH]`.
- `i_valid` in 1: request present.
- `o_ready` out 1: request accepted this cycle if `i_valid`.
- `o_rdata` out ROW_WIDTH: read data.
- `o_raddr` out ADDR_WIDTH: address of the returned read.
- `o_rvalid` out 1: `o_rdata`/`o_raddr` valid.

## Operation
- `o_ready = ~i_halt & ~srst` (combinational). Accept = `i_valid & o_ready`.
- Accepted write (`i_wen=1`):
  - For each b with `i_wmask[b]=1`, row `i_addr` block b ← `i_data` block b.
  - Blocks with mask 0 are unchanged.
  - `i_wmask=0` is a legal no-op.
  - No response; `o_rvalid` deasserts next cycle.
- Accepted read (`i_wen=0`):
  - Next cycle: `o_rdata` = row contents as of the accept edge, `o_raddr=i_addr`, `o_rvalid=1`.
  - `i_wmask`/`i_data` are ignored.
- Non-accepted cycle while not halted: `o_rvalid` ← 0. `o_rdata`/`o_raddr` hold their last values.
- Halt:
  - Array, `o_rdata`, `o_raddr` and `o_rvalid` all hold.
  - A response present when halt rises stays asserted through the halt. Consumers must already gate on halt.
  - Implemented by gating state updates with `clock_gater`, or by an equivalent enable.
- No state machine beyond the 1-deep response register. The block is a pure responder; the initializer is responsible for zeroing contents.

## Timing
- Reset (`srst=1` at a rising edge): `o_rdata=0`, `o_raddr=0`, `o_rvalid=0`.
  - Array contents are not reset.
  - Any request presented in a reset cycle is not accepted (`o_ready=0`), so a write in that cycle is not performed.
  - Reset has priority over halt.
- Reset mid-operation: a pending response is dropped (`o_rvalid=0` next cycle). No partial writes occur.
- Read latency: 1 cycle, throughput 1 request/cycle.
- Write→read same address on consecutive cycles: the read returns the newly written data, because the write commits at edge N and the read samples after it.
- Read contents of a never-written row are undefined (X in simulation). This is legal only before the initializer has completed.
- Address range: all `2**ADDR_WIDTH` rows are valid. There is no wrap or out-of-range case.
- Back-to-back reads: `o_rvalid` stays high with a new `o_raddr` every cycle.

## Structure
- Shared package `shared_params.vh` holds `ADDR_WIDTH`, `ROW_WIDTH`, `NUM_BLOCKS`, and derived `BLOCK_WIDTH`/`NUM_ROWS`. The block adds no new shared constants.
- Reuse the existing `clock_gater` for the halt freeze.
- The masked write is a generate loop over `NUM_BLOCKS`.
- No further sub-module.

## Test plan
- Reset, then 64 full-mask writes of 0 (initializer pattern), then read all 64 rows → every `o_rdata=8'h00`, `o_raddr` echoes the address, 1-cycle latency, `o_rvalid` continuous.
- Write `8'hFF` mask `4'b1111` to addr 5, then write `8'h00` mask `4'b0101` to addr 5, then read addr 5 → `o_rdata=8'hCC`.
- Write `8'hA5` to addr 63, then read addr 63 in the very next cycle → `o_rdata=8'hA5`, `o_raddr=63`.
- Read addr 3 accepted, then `i_halt=1` for 4 cycles with `i_valid` held → `o_ready=0`, `o_rvalid=1`/`o_rdata` held all 4 cycles, no new access. After release the held request is accepted.
- Assert `srst` in the cycle after a read accept, with a simultaneous write of `8'h77` to addr 9 → `o_rvalid=0`, `o_rdata=0`, and addr 9 retains its prior value on a subsequent read.
- Write with `i_wmask=4'b0000` to addr 2 holding `8'h3C` → a subsequent read returns `8'h3C`.
